// File: rtl/fp_decode_stage_if.sv
// Bundles the decode-stage handshake, the instruction input and the decoded control outputs.
// The optional rs3 signal exists only when RVF_FMA_EN is defined.
interface fp_decode_stage_if #(
    parameter int FP_OP_W = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         alu_op;
    logic [1:0]         ext_imm_sel;
    logic               mem_write;
    logic               mem_read;
    logic               reg_write;
    logic [1:0]         res_rd;
    logic               alu_src2;
    logic               pc_jalr;
    logic               pc_jal;
    logic               branch;
    logic               fp_reg_we;
    logic [1:0]         fp_reg_fds_sel;
    logic [FP_OP_W-1:0] fp_alu_op;
    logic               data_mem_in_sel;
    logic               fp_alu_in1_sel;
    logic               fp_2reg_sel;
    logic [2:0]         rm;
    logic               illegal;
    logic               fpu_busy;
`ifdef RVF_FMA_EN
    logic [4:0]         rs3;
`endif

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, alu_op, ext_imm_sel, mem_write, mem_read, reg_write,
               res_rd, alu_src2, pc_jalr, pc_jal, branch, fp_reg_we, fp_reg_fds_sel,
               fp_alu_op, data_mem_in_sel, fp_alu_in1_sel, fp_2reg_sel, rm, illegal,
               fpu_busy
`ifdef RVF_FMA_EN
             , rs3
`endif
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, alu_op, ext_imm_sel, mem_write, mem_read, reg_write,
               res_rd, alu_src2, pc_jalr, pc_jal, branch, fp_reg_we, fp_reg_fds_sel,
               fp_alu_op, data_mem_in_sel, fp_alu_in1_sel, fp_2reg_sel, rm, illegal,
               fpu_busy
`ifdef RVF_FMA_EN
             , rs3
`endif
    );
endinterface

// File: rtl/fp_decode_stage.sv
// Registered RV32I+F decode stage: one-entry output register with valid/ready handshake,
// deterministic zero bundle plus illegal flag for unimplemented encodings, and an FPU busy
// down-counter that stalls FP-class entries while an FDIV/FSQRT is in flight.
// Optional FMA decode (FMADD/FMSUB/FNMSUB/FNMADD and the rs3 output) is enabled by RVF_FMA_EN.
module fp_decode_stage #(
    parameter int FP_OP_W  = 5,
    parameter int DIV_LAT  = 16,
    parameter int SQRT_LAT = 24,
    parameter int CNT_W    = 6
) (
    input logic              clk,
    input logic              rst_n,
    fp_decode_stage_if.slave bus
);
    typedef struct packed {
        logic [1:0]         alu_op;
        logic [1:0]         ext_imm_sel;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic [1:0]         res_rd;
        logic               alu_src2;
        logic               pc_jalr;
        logic               pc_jal;
        logic               branch;
        logic               fp_reg_we;
        logic [1:0]         fp_reg_fds_sel;
        logic [FP_OP_W-1:0] fp_alu_op;
        logic               data_mem_in_sel;
        logic               fp_alu_in1_sel;
        logic               fp_2reg_sel;
        logic [2:0]         rm;
        logic               illegal;
        logic               fpu_class;
        logic               is_div;
        logic               is_sqrt;
`ifdef RVF_FMA_EN
        logic [4:0]         rs3;
`endif
    } ctrl_t;

    ctrl_t            d;
    ctrl_t            q;
    logic             entry_v;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             out_valid_i;
    logic             in_ready_i;
    logic             load;
    logic             issue;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs2;
    logic       unused_bits;

    assign opcode      = bus.in_instr[6:0];
    assign f3          = bus.in_instr[14:12];
    assign f7          = bus.in_instr[31:25];
    assign rs2         = bus.in_instr[24:20];
    assign unused_bits = ^{bus.in_instr[19:15], bus.in_instr[11:7]};

    assign busy        = (cnt != '0);
    assign out_valid_i = entry_v && !(q.fpu_class && busy);
    assign issue       = out_valid_i && bus.out_ready;
    // Reset and flush both hold off new instructions for that cycle.
    assign in_ready_i  = rst_n && !bus.flush && (!entry_v || issue);
    assign load        = bus.in_valid && in_ready_i;

    // Combinational decode of the incoming word; anything unmatched collapses to the illegal bundle.
    always_comb begin
        d = '0;
        case (opcode)
            7'd51:  begin d.alu_op = 2'b10; d.reg_write = 1'b1; end
            7'd19:  begin d.alu_op = 2'b10; d.reg_write = 1'b1; d.alu_src2 = 1'b1; end
            7'd3:   begin d.mem_read = 1'b1; d.reg_write = 1'b1; d.res_rd = 2'b01; d.alu_src2 = 1'b1; end
            7'd103: begin d.reg_write = 1'b1; d.res_rd = 2'b10; d.alu_src2 = 1'b1; d.pc_jalr = 1'b1; end
            7'd35:  begin d.ext_imm_sel = 2'b01; d.mem_write = 1'b1; d.alu_src2 = 1'b1; end
            7'd99:  begin d.alu_op = 2'b01; d.ext_imm_sel = 2'b10; d.branch = 1'b1; end
            7'd111: begin d.ext_imm_sel = 2'b11; d.reg_write = 1'b1; d.res_rd = 2'b10; d.pc_jal = 1'b1; end
            7'd7: begin
                if (f3 == 3'b010) begin
                    d.mem_read       = 1'b1;
                    d.res_rd         = 2'b01;
                    d.alu_src2       = 1'b1;
                    d.fp_reg_we      = 1'b1;
                    d.fp_reg_fds_sel = 2'b01;
                    d.fpu_class      = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            7'd39: begin
                if (f3 == 3'b010) begin
                    d.ext_imm_sel     = 2'b01;
                    d.mem_write       = 1'b1;
                    d.alu_src2        = 1'b1;
                    d.data_mem_in_sel = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            7'd83: begin
                d.alu_op    = 2'b10;
                d.fpu_class = 1'b1;
                case (f7)
                    7'b0000000: begin d.fp_alu_op = FP_OP_W'(0); d.fp_reg_we = 1'b1; end
                    7'b0000100: begin d.fp_alu_op = FP_OP_W'(1); d.fp_reg_we = 1'b1; end
                    7'b0001000: begin d.fp_alu_op = FP_OP_W'(2); d.fp_reg_we = 1'b1; end
                    7'b0001100: begin d.fp_alu_op = FP_OP_W'(15); d.fp_reg_we = 1'b1; d.is_div = 1'b1; end
                    7'b0101100: begin
                        d.fp_alu_op = FP_OP_W'(16);
                        d.fp_reg_we = 1'b1;
                        d.is_sqrt   = 1'b1;
                        d.illegal   = (rs2 != 5'd0);
                    end
                    7'b0010000: begin
                        d.fp_reg_we = 1'b1;
                        case (f3)
                            3'b000:  d.fp_alu_op = FP_OP_W'(10);
                            3'b001:  d.fp_alu_op = FP_OP_W'(11);
                            3'b010:  d.fp_alu_op = FP_OP_W'(12);
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    7'b0010100: begin
                        d.fp_reg_we = 1'b1;
                        case (f3)
                            3'b000:  d.fp_alu_op = FP_OP_W'(7);
                            3'b001:  d.fp_alu_op = FP_OP_W'(8);
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    7'b1010000: begin
                        d.reg_write   = 1'b1;
                        d.res_rd      = 2'b11;
                        d.fp_2reg_sel = 1'b1;
                        case (f3)
                            3'b010:  d.fp_alu_op = FP_OP_W'(4);
                            3'b001:  d.fp_alu_op = FP_OP_W'(5);
                            3'b000:  d.fp_alu_op = FP_OP_W'(6);
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    7'b1100000: begin
                        d.fp_alu_op   = FP_OP_W'(13);
                        d.reg_write   = 1'b1;
                        d.res_rd      = 2'b11;
                        d.fp_2reg_sel = 1'b1;
                        d.illegal     = (rs2[4:1] != 4'd0);
                    end
                    7'b1101000: begin
                        d.fp_alu_op      = FP_OP_W'(14);
                        d.fp_reg_we      = 1'b1;
                        d.fp_alu_in1_sel = 1'b1;
                        d.illegal        = (rs2[4:1] != 4'd0);
                    end
                    7'b1110000: begin
                        d.reg_write = 1'b1;
                        d.res_rd    = 2'b11;
                        if (rs2 == 5'd0 && f3 == 3'b000) begin
                            d.fp_alu_op = FP_OP_W'(3);      // FMV.X.W: raw move, no FPU result
                        end else if (rs2 == 5'd0 && f3 == 3'b001) begin
                            d.fp_alu_op   = FP_OP_W'(9);
                            d.fp_2reg_sel = 1'b1;
                        end else begin
                            d.illegal = 1'b1;
                        end
                    end
                    7'b1111000: begin
                        d.fp_alu_op      = FP_OP_W'(3);     // FMV.W.X takes rs1 straight from the int file
                        d.fp_reg_we      = 1'b1;
                        d.fp_reg_fds_sel = 2'b10;
                        d.illegal        = !(rs2 == 5'd0 && f3 == 3'b000);
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
`ifdef RVF_FMA_EN
            7'd67, 7'd71, 7'd75, 7'd79: begin
                d.alu_op    = 2'b10;
                d.fp_reg_we = 1'b1;
                d.fpu_class = 1'b1;
                d.rs3       = bus.in_instr[31:27];
                d.fp_alu_op = FP_OP_W'(17 + int'(opcode[3:2]));
                d.illegal   = (bus.in_instr[26:25] != 2'b00);
            end
`endif
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end else begin
            d.rm = f3;
        end
    end

    // Output entry register and FPU busy down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_v <= 1'b0;
            q       <= '0;
            cnt     <= '0;
        end else begin
            if (bus.flush) begin
                entry_v <= 1'b0;
            end else if (load) begin
                entry_v <= 1'b1;
                q       <= d;
            end else if (issue) begin
                entry_v <= 1'b0;
            end

            // A stalled FP entry cannot issue, so a reload never lands on a nonzero count.
            if (issue && q.is_div) begin
                cnt <= CNT_W'(DIV_LAT);
            end else if (issue && q.is_sqrt) begin
                cnt <= CNT_W'(SQRT_LAT);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign bus.in_ready        = in_ready_i;
    assign bus.out_valid       = out_valid_i;
    assign bus.fpu_busy        = busy;
    assign bus.alu_op          = q.alu_op;
    assign bus.ext_imm_sel     = q.ext_imm_sel;
    assign bus.mem_write       = q.mem_write;
    assign bus.mem_read        = q.mem_read;
    assign bus.reg_write       = q.reg_write;
    assign bus.res_rd          = q.res_rd;
    assign bus.alu_src2        = q.alu_src2;
    assign bus.pc_jalr         = q.pc_jalr;
    assign bus.pc_jal          = q.pc_jal;
    assign bus.branch          = q.branch;
    assign bus.fp_reg_we       = q.fp_reg_we;
    assign bus.fp_reg_fds_sel  = q.fp_reg_fds_sel;
    assign bus.fp_alu_op       = q.fp_alu_op;
    assign bus.data_mem_in_sel = q.data_mem_in_sel;
    assign bus.fp_alu_in1_sel  = q.fp_alu_in1_sel;
    assign bus.fp_2reg_sel     = q.fp_2reg_sel;
    assign bus.rm              = q.rm;
    assign bus.illegal         = q.illegal;
`ifdef RVF_FMA_EN
    assign bus.rs3             = q.rs3;
`endif
endmodule

// File: tb/tb_fp_decode_stage.sv
// Directed bench for fp_decode_stage: decode tables, FDIV/FSQRT interlock, back-pressure,
// flush and reset. Control bundle is compared as one packed word in port order:
// alu_op, ext, mw, mr, rw, res_rd, src2, jalr, jal, br, fp_we, fds, fp_alu_op, dmis, in1, 2reg, illegal.
module tb_fp_decode_stage;
    localparam int DIV_LAT  = 16;
    localparam int SQRT_LAT = 24;

    localparam logic [31:0] I_FADD  = 32'h003100D3;
    localparam logic [31:0] I_FDIV  = 32'h183100D3;
    localparam logic [31:0] I_FSQRT = 32'h580100D3;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_LW    = 32'h0000A083;

    localparam logic [24:0] C_FADD = 25'b10_00_0_0_0_00_0_0_0_0_1_00_00000_0_0_0_0;
    localparam logic [24:0] C_ADD  = 25'b10_00_0_0_1_00_0_0_0_0_0_00_00000_0_0_0_0;
    localparam logic [24:0] C_ADDI = 25'b10_00_0_0_1_00_1_0_0_0_0_00_00000_0_0_0_0;
    localparam logic [24:0] C_LW   = 25'b00_00_0_1_1_01_1_0_0_0_0_00_00000_0_0_0_0;
    localparam logic [24:0] C_ILL  = 25'b00_00_0_0_0_00_0_0_0_0_0_00_00000_0_0_0_1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_decode_stage_if #(.FP_OP_W(5)) bus ();

    fp_decode_stage #(.FP_OP_W(5), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] ctl();
        return {bus.alu_op, bus.ext_imm_sel, bus.mem_write, bus.mem_read, bus.reg_write,
                bus.res_rd, bus.alu_src2, bus.pc_jalr, bus.pc_jal, bus.branch, bus.fp_reg_we,
                bus.fp_reg_fds_sel, bus.fp_alu_op, bus.data_mem_in_sel, bus.fp_alu_in1_sel,
                bus.fp_2reg_sel, bus.illegal};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to an idle stage, check its bundle, then let it drain.
    task automatic drive_one(input string name, input logic [31:0] instr,
                             input logic [24:0] exp, input logic [2:0] exp_rm);
        bus.in_valid = 1'b1; bus.in_instr = instr; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready got %b want 1", name, bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_out_valid got %b want 1", name, bus.out_valid); end
        n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL %s_bundle got %b want %b", name, ctl(), exp); end
        n_cmp++; if (bus.rm !== exp_rm) begin n_bad++; $display("FAIL %s_rm got %0d want %0d", name, bus.rm, exp_rm); end
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.out_ready = 1'b0;
        cyc(); cyc();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.fpu_busy !== 1'b0) begin n_bad++; $display("FAIL rst_fpu_busy got %b want 0", bus.fpu_busy); end
        n_cmp++; if (ctl() !== 25'b0) begin n_bad++; $display("FAIL rst_bundle got %b want 0", ctl()); end
        n_cmp++; if (bus.rm !== 3'd0) begin n_bad++; $display("FAIL rst_rm got %0d want 0", bus.rm); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
        cyc();
    endtask

    task automatic test_fadd();
        drive_one("fadd", I_FADD, C_FADD, 3'd0);
    endtask

    task automatic test_int_decode();
        drive_one("r_add", I_ADD,         C_ADD,  3'd0);
        drive_one("addi",  I_ADDI,        C_ADDI, 3'd0);
        drive_one("lw",    I_LW,          C_LW,   3'd2);
        drive_one("jalr",  32'h00008067,  25'b00_00_0_0_1_10_1_1_0_0_0_00_00000_0_0_0_0, 3'd0);
        drive_one("sw",    32'h00112023,  25'b00_01_1_0_0_00_1_0_0_0_0_00_00000_0_0_0_0, 3'd2);
        drive_one("beq",   32'h00208063,  25'b01_10_0_0_0_00_0_0_0_1_0_00_00000_0_0_0_0, 3'd0);
        drive_one("jal",   32'h0000006F,  25'b00_11_0_0_1_10_0_0_1_0_0_00_00000_0_0_0_0, 3'd0);
    endtask

    task automatic test_fp_decode();
        drive_one("flw",      32'h00002087, 25'b00_00_0_1_0_01_1_0_0_0_1_01_00000_0_0_0_0, 3'd2);
        drive_one("fsw",      32'h00112027, 25'b00_01_1_0_0_00_1_0_0_0_0_00_00000_1_0_0_0, 3'd2);
        drive_one("fmul",     32'h103100D3, 25'b10_00_0_0_0_00_0_0_0_0_1_00_00010_0_0_0_0, 3'd0);
        drive_one("feq",      32'hA03120D3, 25'b10_00_0_0_1_11_0_0_0_0_0_00_00100_0_0_1_0, 3'd2);
        drive_one("fcvt_w_s", 32'hC00100D3, 25'b10_00_0_0_1_11_0_0_0_0_0_00_01101_0_0_1_0, 3'd0);
        drive_one("fcvt_s_w", 32'hD00100D3, 25'b10_00_0_0_0_00_0_0_0_0_1_00_01110_0_1_0_0, 3'd0);
`ifdef RVF_FMA_EN
        drive_one("fmadd",    32'h00000043, 25'b10_00_0_0_0_00_0_0_0_0_1_00_10001_0_0_0_0, 3'd0);
`else
        drive_one("fmadd_off", 32'h00000043, C_ILL, 3'd0);
`endif
    endtask

    task automatic test_illegal();
        drive_one("ill_ffff",     32'hFFFFFFFF, C_ILL, 3'd0);
        drive_one("after_ill_lw", I_LW,         C_LW,  3'd2);
        drive_one("ill_flw_f3",   32'h00003087, C_ILL, 3'd0);
        drive_one("ill_op83_f7",  32'h023100D3, C_ILL, 3'd0);
        drive_one("ill_fsqrt_rs2", 32'h583100D3, C_ILL, 3'd0);
    endtask

    task automatic test_fdiv_interlock();
        int busy_n = 0;
        int viol   = 0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = I_FDIV;
        cyc();
        bus.in_instr = I_FADD;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL fdiv_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.fp_alu_op !== 5'd15) begin n_bad++; $display("FAIL fdiv_op got %0d want 15", bus.fp_alu_op); end
        n_cmp++; if (bus.fpu_busy !== 1'b0) begin n_bad++; $display("FAIL fdiv_pre_busy got %b want 0", bus.fpu_busy); end
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.fpu_busy !== 1'b1) break;
            busy_n++;
            if (bus.out_valid !== 1'b0) viol++;
            cyc();
        end
        n_cmp++; if (busy_n !== DIV_LAT) begin n_bad++; $display("FAIL fdiv_busy_cycles got %0d want %0d", busy_n, DIV_LAT); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL fdiv_stall_leak got %0d want 0", viol); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL fadd_release_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (ctl() !== C_FADD) begin n_bad++; $display("FAIL fadd_release_bundle got %b want %b", ctl(), C_FADD); end
        cyc();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fadd_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sqrt_int_bypass();
        int busy_n = 0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = I_FSQRT;
        cyc();
        bus.in_instr = I_ADD;
        #1;
        n_cmp++; if (bus.fp_alu_op !== 5'd16) begin n_bad++; $display("FAIL fsqrt_op got %0d want 16", bus.fp_alu_op); end
        cyc();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.fpu_busy !== 1'b1) begin n_bad++; $display("FAIL sqrt_busy got %b want 1", bus.fpu_busy); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_no_stall got %b want 1", bus.out_valid); end
        n_cmp++; if (ctl() !== C_ADD) begin n_bad++; $display("FAIL add_bundle got %b want %b", ctl(), C_ADD); end
        busy_n = 1;
        cyc();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drained got %b want 0", bus.out_valid); end
        for (int i = 0; i < 40; i++) begin
            if (bus.fpu_busy !== 1'b1) break;
            busy_n++;
            cyc();
        end
        n_cmp++; if (busy_n !== SQRT_LAT) begin n_bad++; $display("FAIL sqrt_busy_cycles got %0d want %0d", busy_n, SQRT_LAT); end
    endtask

    task automatic test_backpressure();
        int bad_hold = 0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = I_ADDI;
        cyc();
        bus.in_instr = I_LW;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || ctl() !== C_ADDI) bad_hold++;
            cyc();
        end
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad_hold); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (ctl() !== C_LW) begin n_bad++; $display("FAIL bp_next_bundle got %b want %b", ctl(), C_LW); end
        bus.out_ready = 1'b1;
        cyc();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int busy_n = 0;
        int leak   = 0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = I_FDIV;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = I_ADD;
        cyc();
        bus.flush = 1'b1; bus.in_instr = I_LW;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        cyc();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_empty_ready got %b want 1", bus.in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (bus.fpu_busy !== 1'b1) break;
            busy_n++;
            if (bus.out_valid !== 1'b0) leak++;
            cyc();
        end
        n_cmp++; if (busy_n !== DIV_LAT - 2) begin n_bad++; $display("FAIL flush_busy_left got %0d want %0d", busy_n, DIV_LAT - 2); end
        n_cmp++; if (leak !== 0) begin n_bad++; $display("FAIL flush_leak got %0d want 0", leak); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = I_FDIV;
        cyc();
        bus.in_instr = I_FADD;
        cyc();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.fpu_busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", bus.fpu_busy); end
        rst_n = 1'b0;
        cyc();
        n_cmp++; if (bus.fpu_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.fpu_busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (ctl() !== 25'b0) begin n_bad++; $display("FAIL rmid_bundle got %b want 0", ctl()); end
        rst_n = 1'b1;
        cyc();
        drive_one("rmid_after_add", I_ADD, C_ADD, 3'd0);
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_int_decode();
        test_fp_decode();
        test_illegal();
        test_fdiv_interlock();
        test_sqrt_int_bypass();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule
